// File: rtl/float_mul_core.sv
// rtl/float_mul_core.sv - Iterative shift-add mantissa multiply and exponent add ahead of normalization.
// One operand pair in flight; result held until the normalizer side accepts it.
module float_mul_core #(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E+M:0]     ina,
    input  logic [E+M:0]     inb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             outs,
    output logic [E:0]       oute,
    output logic [2*M+1:0]   outm,
    output logic             outz
);

    localparam int PW = 2 * M + 2;
    localparam int CW = $clog2(M + 1);
    localparam logic [E:0] BIAS = (E+1)'((1 << (E - 1)) - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   mcand_q;
    logic [M:0]      mplier_q;
    logic [PW-1:0]   acc_q;
    logic            zero_q;
    logic            outs_q;
    logic [E:0]      oute_q;
    logic [PW-1:0]   outm_q;
    logic            outz_q;

    logic [E-1:0]    exp_a;
    logic [E-1:0]    exp_b;
    logic [M:0]      mant_a;
    logic [M:0]      mant_b;
    logic            a_zero;
    logic            b_zero;
    logic [E:0]      exp_sum_d;
    logic [PW-1:0]   acc_d;

    assign exp_a  = ina[E+M-1:M];
    assign exp_b  = inb[E+M-1:M];
    assign mant_a = {|exp_a, ina[M-1:0]};
    assign mant_b = {|exp_b, inb[M-1:0]};
    assign a_zero = (ina[E+M-1:0] == '0);
    assign b_zero = (inb[E+M-1:0] == '0);

    // Only the low E+1 bits are kept, so the sum is formed directly modulo 2^(E+1).
    assign exp_sum_d = {1'b0, exp_a} + {1'b0, exp_b} - BIAS;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            outs_q   <= 1'b0;
            oute_q   <= '0;
            outm_q   <= '0;
            outz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= {{(M+1){1'b0}}, mant_a};
                        mplier_q <= mant_b;
                        acc_q    <= '0;
                        cnt_q    <= CW'(M);
                        zero_q   <= a_zero | b_zero;
                        outs_q   <= ina[E+M] ^ inb[E+M];
                        oute_q   <= (a_zero | b_zero) ? '0 : exp_sum_d;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (cnt_q == '0) begin
                        outm_q  <= zero_q ? '0 : acc_d;
                        outz_q  <= zero_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign outs      = outs_q;
    assign oute      = oute_q;
    assign outm      = outm_q;
    assign outz      = outz_q;

endmodule
